sr_flop_bank: RTL and testbench
===============================

// Module: sr_flop_bank
// PURPOSE
//  WIDTH independent clocked set/reset storage elements. Successor to the free-running cross-coupled NOR latch:
//  - fully synchronous, so no races or oscillation
//  - input glitch filter on each channel
//  - selectable S&R conflict resolution
//  - per-channel and sticky conflict flags
//  Sits between raw control/status strobes and downstream FSMs that need a clean, held flag.
// PARAMETERS
//  WIDTH       8   number of independent SR channels (1..32)
//  FILTER_LEN  1   cycles {S,R} must be stable before acting (1..15); 1 = no filtering
//  MODE        0   S&R=11 resolution: 0 reset-dominant, 1 set-dominant, 2 toggle, 3 hold
// PORTS
//  clk              in   1      single clock, rising edge
//  rst              in   1      synchronous, active-high reset
//  S                in   WIDTH  per-channel set request
//  R                in   WIDTH  per-channel reset request
//  clr_conflict     in   1      clears conflict_sticky
//  Q                out  WIDTH  registered state
//  Qbar             out  WIDTH  always exactly ~Q (registered, never both 1 or both 0)
//  conflict         out  WIDTH  channel's qualified pair is 11 this cycle (registered)
//  conflict_sticky  out  1      OR-accumulated conflict since last clear
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - Q=0, Qbar='1, conflict=0, conflict_sticky=0
//   - all filter counters=0, prev pairs=00, toggle arm=1
//   - reset mid-filter discards partial qualification
//  Filter, per channel:
//   - pair p={S,R}; prev=p registered
//   - if p!=prev: cnt=0
//   - else: cnt=min(cnt+1, FILTER_LEN-1)
//   - p is "qualified" in the cycle where p==prev and cnt==FILTER_LEN-1
//   - FILTER_LEN=1: p is qualified immediately (prev/cnt ignored)
//  Latency: a pair held from cycle k is acted on at the edge ending cycle k+FILTER_LEN-1
//   - i.e. Q changes FILTER_LEN edges after the pair is first presented
//   - a pulse shorter than FILTER_LEN cycles has no effect
//  Action on a qualified pair:
//   - 10: Q<=1
//   - 01: Q<=0
//   - 00: hold
//   - 11: per MODE: 0 -> Q<=0; 1 -> Q<=1; 3 -> hold
//   - 11 with MODE 2: Q<=~Q once when it first qualifies; arm clears
//   - arm re-sets when the pair leaves 11; a continuously held 11 toggles exactly once
//  Unqualified pair: Q holds.
//  conflict[i] <= qualified && p==11 (all modes); conflict=0 while unqualified.
//  conflict_sticky:
//   - <= (sticky & ~clr_conflict) | (|next_conflict)
//   - same-cycle clear and new conflict -> stays 1
//   - clr_conflict has no effect on Q
//  Channels fully independent; counters never wrap (saturate).
// STRUCTURE
//  Shared package sr_pkg:
//   - localparams SR_MODE_RDOM=0, SR_MODE_SDOM=1, SR_MODE_TOGGLE=2, SR_MODE_HOLD=3
//   - typedef sr_pair_t (2-bit {S,R})
//  Sub-module sr_cell (one channel):
//   - contents: filter counter, prev pair, arm, Q, conflict bit
//   - parameters FILTER_LEN, MODE
//  Top: generate loop of WIDTH sr_cell + sticky OR-reduce register.
//  Elaboration check: FILTER_LEN in 1..15, MODE in 0..3, else $fatal.
// TESTING
//  1. Reset, W=8, F=1: rst 2 cycles
//     -> Q=00, Qbar=FF, conflict=0, sticky=0
//  2. F=1, M=0: S=01 one cycle
//     -> Q[0]=1 next edge
//     -> then R=01 gives Q[0]=0
//     -> then S=R=01 gives Q[0]=0, conflict[0]=1, sticky=1
//  3. F=3: S[2] pulse of 2 cycles
//     -> Q unchanged
//     -> S[2] held 3 cycles gives Q[2]=1 exactly 3 edges after first high
//  4. M=2, F=1: S=R=1 on ch0 held 5 cycles
//     -> Q[0] toggles once
//     -> drop to 00 for 1 cycle, reapply 11: toggles again
//  5. M=1 and M=3, S=R=11 from Q=0
//     -> M1: Q=1; M3: Q stays 0
//     -> conflict asserted in both
//  6. Sticky: conflict and clr_conflict in same cycle
//     -> sticky=1
//     -> clr alone next cycle gives 0
//     -> rst asserted mid-filter (F=4, cnt=2) gives no Q change after release

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types and mode encodings for the clocked SR flag bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sr_pkg;

  localparam int SR_MODE_RDOM   = 0;
  localparam int SR_MODE_SDOM   = 1;
  localparam int SR_MODE_TOGGLE = 2;
  localparam int SR_MODE_HOLD   = 3;

  // {S,R} request pair as seen by one channel
  typedef logic [1:0] sr_pair_t;

  localparam sr_pair_t SR_PAIR_IDLE  = 2'b00;
  localparam sr_pair_t SR_PAIR_RST   = 2'b01;
  localparam sr_pair_t SR_PAIR_SET   = 2'b10;
  localparam sr_pair_t SR_PAIR_BOTH  = 2'b11;

endpackage

// File: rtl/sr_cell.sv
// One filtered, clocked SR channel with conflict detection.
// Latency: a stable pair acts FILTER_LEN edges after it is first presented.
// Backpressure: none; requests not held long enough are dropped.
module sr_cell
  import sr_pkg::*;
#(
  parameter int FILTER_LEN = 1,
  parameter int MODE       = SR_MODE_RDOM
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar,
  output logic conflict,
  output logic conflict_nxt
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  sr_pair_t   pair;
  sr_pair_t   prev_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_nxt;
  logic       arm_q;
  logic       arm_nxt;
  logic       qual;
  logic       q_nxt;

  // Qualification looks at the count this cycle would reach, so the pair acts
  // on the edge that completes FILTER_LEN consecutive samples.
  always_comb begin
    pair    = {s, r};
    cnt_nxt = '0;
    if (pair == prev_q) begin
      cnt_nxt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
    end
    if (FILTER_LEN == 1) begin
      qual = 1'b1;
    end else begin
      qual = (pair == prev_q) && (cnt_nxt == CNT_MAX);
    end
  end

  always_comb begin
    q_nxt        = q;
    arm_nxt      = arm_q;
    conflict_nxt = qual && (pair == SR_PAIR_BOTH);
    if (pair != SR_PAIR_BOTH) begin
      arm_nxt = 1'b1;
    end
    if (qual) begin
      unique case (pair)
        SR_PAIR_SET:  q_nxt = 1'b1;
        SR_PAIR_RST:  q_nxt = 1'b0;
        SR_PAIR_BOTH: begin
          if (MODE == SR_MODE_RDOM) begin
            q_nxt = 1'b0;
          end else if (MODE == SR_MODE_SDOM) begin
            q_nxt = 1'b1;
          end else if (MODE == SR_MODE_TOGGLE) begin
            // one toggle per continuous run of 11
            if (arm_q) begin
              q_nxt   = ~q;
              arm_nxt = 1'b0;
            end
          end
        end
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= SR_PAIR_IDLE;
      cnt_q    <= '0;
      arm_q    <= 1'b1;
      q        <= 1'b0;
      qbar     <= 1'b1;
      conflict <= 1'b0;
    end else begin
      prev_q   <= pair;
      cnt_q    <= cnt_nxt;
      arm_q    <= arm_nxt;
      q        <= q_nxt;
      qbar     <= ~q_nxt;
      conflict <= conflict_nxt;
    end
  end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH independent filtered SR flags plus a sticky conflict flag.
// Latency: FILTER_LEN edges from first presentation of a stable {S,R} pair.
// Backpressure: none; inputs are level strobes sampled every cycle.
module sr_flop_bank
  import sr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 1,
  parameter int MODE       = SR_MODE_RDOM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_sticky
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "sr_flop_bank: WIDTH must be 1..32");
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter
    $fatal(1, "sr_flop_bank: FILTER_LEN must be 1..15");
  end
  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $fatal(1, "sr_flop_bank: MODE must be 0..3");
  end

  logic [WIDTH-1:0] conflict_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .FILTER_LEN (FILTER_LEN),
      .MODE       (MODE)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .s            (S[i]),
      .r            (R[i]),
      .q            (Q[i]),
      .qbar         (Qbar[i]),
      .conflict     (conflict[i]),
      .conflict_nxt (conflict_nxt[i])
    );
  end

  // a new conflict wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_sticky <= 1'b0;
    end else begin
      conflict_sticky <= (conflict_sticky & ~clr_conflict) | (|conflict_nxt);
    end
  end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench over six FILTER_LEN/MODE configurations sharing one stimulus,
// with a run-length reference model compared every cycle.
module tb_sr_flop_bank;

  localparam int NCFG = 6;

  function automatic int cfg_f(input int i);
    case (i)
      1:       return 3;
      5:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_m(input int i);
    case (i)
      2:       return 2;
      3:       return 1;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] S;
  logic [7:0] R;
  logic       clr;

  logic [7:0] q_w  [NCFG];
  logic [7:0] qb_w [NCFG];
  logic [7:0] cf_w [NCFG];
  logic       st_w [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    sr_flop_bank #(
      .WIDTH      (8),
      .FILTER_LEN (cfg_f(g)),
      .MODE       (cfg_m(g))
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .S               (S),
      .R               (R),
      .clr_conflict    (clr),
      .Q               (q_w[g]),
      .Qbar            (qb_w[g]),
      .conflict        (cf_w[g]),
      .conflict_sticky (st_w[g])
    );
  end

  // Reference model: a pair acts once it has been seen on FILTER_LEN
  // consecutive samples; toggle fires only on the sample that first reaches it.
  logic [7:0] mq    [NCFG];
  logic [7:0] mconf [NCFG];
  logic       mst   [NCFG];
  logic [1:0] mprev [NCFG][8];
  int         mrun  [NCFG][8];
  logic       mvalid = 1'b0;

  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      logic any_c;
      any_c = 1'b0;
      for (int ch = 0; ch < 8; ch++) begin
        logic [1:0] p;
        logic       qual;
        p = {S[ch], R[ch]};
        if (rst) begin
          mq[c][ch]    = 1'b0;
          mconf[c][ch] = 1'b0;
          mprev[c][ch] = 2'b00;
          mrun[c][ch]  = 1;
        end else begin
          mrun[c][ch]  = (p == mprev[c][ch]) ? ((mrun[c][ch] < 16) ? mrun[c][ch] + 1 : 16) : 1;
          mprev[c][ch] = p;
          qual         = (mrun[c][ch] >= cfg_f(c));
          mconf[c][ch] = qual && (p == 2'b11);
          if (qual) begin
            case (p)
              2'b10: mq[c][ch] = 1'b1;
              2'b01: mq[c][ch] = 1'b0;
              2'b11: begin
                case (cfg_m(c))
                  0: mq[c][ch] = 1'b0;
                  1: mq[c][ch] = 1'b1;
                  2: if (mrun[c][ch] == cfg_f(c)) mq[c][ch] = ~mq[c][ch];
                  default: ;
                endcase
              end
              default: ;
            endcase
          end
        end
        any_c = any_c | mconf[c][ch];
      end
      mst[c] = rst ? 1'b0 : ((mst[c] & ~clr) | any_c);
    end
    if (rst) mvalid = 1'b1;
  end

  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (q_w[c] !== mq[c] || qb_w[c] !== ~mq[c] || cf_w[c] !== mconf[c] || st_w[c] !== mst[c]) begin
          errors++;
          $display("FAIL model cfg%0d: got Q=%h Qbar=%h conf=%h sticky=%b expected Q=%h Qbar=%h conf=%h sticky=%b",
                   c, q_w[c], qb_w[c], cf_w[c], st_w[c], mq[c], ~mq[c], mconf[c], mst[c]);
        end
      end
    end
  end

  task automatic cyc(input logic [7:0] s, input logic [7:0] r, input logic c, input logic x);
    S   = s;
    R   = r;
    clr = c;
    rst = x;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    S   = '0;
    R   = '0;
    clr = 1'b0;
    @(negedge clk);

    // reset state
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    chk("rst_q",      q_w[0],  8'h00);
    chk("rst_qbar",   qb_w[0], 8'hff);
    chk("rst_conf",   cf_w[0], 8'h00);
    chk("rst_sticky", {7'b0, st_w[0]}, 8'h00);

    // set, reset, conflict with no filtering, reset-dominant
    cyc(8'h01, 8'h00, 1'b0, 1'b0);
    chk("f1_set_q", q_w[0], 8'h01);
    cyc(8'h00, 8'h01, 1'b0, 1'b0);
    chk("f1_rst_q", q_w[0], 8'h00);
    cyc(8'h01, 8'h01, 1'b0, 1'b0);
    chk("f1_both_q",      q_w[0], 8'h00);
    chk("f1_both_conf",   cf_w[0], 8'h01);
    chk("f1_both_sticky", {7'b0, st_w[0]}, 8'h01);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    chk("f1_clr_sticky", {7'b0, st_w[0]}, 8'h00);

    // FILTER_LEN=3: short pulse ignored, held pulse acts on the third edge
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    chk("f3_pulse_e1", q_w[1], 8'h00);
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    chk("f3_pulse_e2", q_w[1], 8'h00);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("f3_pulse_after", q_w[1], 8'h00);
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    chk("f3_hold_e1", q_w[1], 8'h00);
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    chk("f3_hold_e2", q_w[1], 8'h00);
    cyc(8'h04, 8'h00, 1'b0, 1'b0);
    chk("f3_hold_e3", q_w[1], 8'h04);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);

    // toggle mode: held 11 toggles once, re-armed by a gap
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(8'h01, 8'h01, 1'b0, 1'b0);
      chk("tog_hold_q", q_w[2], 8'h01);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    chk("tog_gap_q", q_w[2], 8'h01);
    cyc(8'h01, 8'h01, 1'b0, 1'b0);
    chk("tog_again_q",    q_w[2], 8'h00);
    chk("tog_again_conf", cf_w[2], 8'h01);

    // set-dominant and hold modes from Q=0
    cyc(8'h00, 8'h00, 1'b0, 1'b1);
    cyc(8'h01, 8'h01, 1'b0, 1'b0);
    chk("sdom_q",    q_w[3], 8'h01);
    chk("hold_q",    q_w[4], 8'h00);
    chk("sdom_conf", cf_w[3], 8'h01);
    chk("hold_conf", cf_w[4], 8'h01);

    // sticky: new conflict beats a same-cycle clear; clear alone drops it
    cyc(8'h01, 8'h01, 1'b1, 1'b0);
    chk("sticky_clr_and_conf", {7'b0, st_w[0]}, 8'h01);
    cyc(8'h00, 8'h00, 1'b1, 1'b0);
    chk("sticky_clr_only", {7'b0, st_w[0]}, 8'h00);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);

    // FILTER_LEN=4: reset at cnt=2 discards the partial qualification
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    cyc(8'h08, 8'h00, 1'b0, 1'b1);
    chk("f4_rst_q", q_w[5], 8'h00);
    cyc(8'h08, 8'h00, 1'b0, 1'b0);
    chk("f4_post_rst_q", q_w[5], 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(8'h00, 8'h00, 1'b0, 1'b0);
      chk("f4_idle_q", q_w[5], 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(8'h08, 8'h00, 1'b0, 1'b0);
      chk("f4_hold_q", q_w[5], (i == 3) ? 8'h08 : 8'h00);
    end
    cyc(8'h00, 8'h00, 1'b0, 1'b0);
    cyc(8'h00, 8'h00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
